// File: rtl/risc32_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
// Contents:
//   md_op_e    - operation codes presented by the EX stage on op_i
//   md_state_e - controller FSM states
//   DIV_ITERS  - quotient bits produced by the divider (one per cycle, word width)
//   DIV_CNT_W  - width of the divider iteration counter
//   is_arith   - true for ops that occupy the multiplier or divider
//   magnitude  - two's complement absolute value helper
package risc32_muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_OP_MULT  = 3'd0,
      MD_OP_MULTU = 3'd1,
      MD_OP_DIV   = 3'd2,
      MD_OP_DIVU  = 3'd3,
      MD_OP_MTHI  = 3'd4,
      MD_OP_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } md_state_e;

   localparam int DIV_ITERS = 32;
   localparam int DIV_CNT_W = $clog2(DIV_ITERS + 1);

   function automatic logic is_arith(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
             (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
   endfunction

   // The most negative word maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] magnitude(input logic [31:0] value, input logic neg);
      return neg ? (32'd0 - value) : value;
   endfunction

endpackage

// File: rtl/risc32_muldiv_ctrl_div_iter.sv
// 32-step restoring divider working on unsigned magnitudes.
// Ports:
//   clk      in   1   clock
//   rst      in   1   synchronous active-high reset
//   load     in   1   capture dividend/divisor and arm DIV_ITERS iterations
//   step     in   1   perform one iteration this cycle
//   dividend in   32  unsigned dividend
//   divisor  in   32  unsigned divisor (never zero when loaded)
//   done     out  1   the iteration happening this cycle is the last one
//   q        out  32  quotient after this cycle's iteration
//   r        out  32  remainder after this cycle's iteration
module risc32_muldiv_ctrl_div_iter
   import risc32_muldiv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] q,
   output logic [31:0] r
);

   logic [31:0]          rem;
   logic [31:0]          quo;
   logic [31:0]          dvs;
   logic [DIV_CNT_W-1:0] cnt;
   logic [32:0]          shifted;
   logic [32:0]          diff;
   logic                 fits;

   // One restoring iteration: shift the next dividend bit into the partial
   // remainder and subtract the divisor if it fits. The outputs are the
   // post-iteration values so the controller can capture the final result on
   // the same edge that performs the last iteration.
   always_comb begin
      shifted = {rem, quo[31]};
      diff    = shifted - {1'b0, dvs};
      fits    = ~diff[32];
      q       = {quo[30:0], fits};
      r       = fits ? diff[31:0] : shifted[31:0];
      done    = step && (cnt == DIV_CNT_W'(1));
   end

   // Iteration state; the quotient is built in place of the consumed dividend bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (load) begin
         rem <= '0;
         quo <= dividend;
         dvs <= divisor;
         cnt <= DIV_CNT_W'(DIV_ITERS);
      end else if (step && (cnt != '0)) begin
         rem <= r;
         quo <= q;
         cnt <= cnt - DIV_CNT_W'(1);
      end
   end

endmodule

// File: rtl/risc32_muldiv_ctrl.sv
// HI/LO write sequencer for the EX stage. Runs MULT/MULTU with a fixed latency,
// DIV/DIVU through the iterative divider, forwards MTHI/MTLO, stalls the
// pipeline while busy and produces a single write strobe per operation.
// Ports:
//   clk       in   1   clock
//   rst       in   1   synchronous active-high reset
//   start_i   in   1   EX presents a HI/LO-writing op this cycle
//   op_i      in   3   md_op_e operation code
//   rs_i      in   32  operand A (dividend / multiplicand / MTHI-MTLO source)
//   rt_i      in   32  operand B (divisor / multiplier)
//   annul_i   in   1   flush: cancel the accepted or in-flight op
//   hi_cur_i  in   32  current HI, kept by MTLO
//   lo_cur_i  in   32  current LO, kept by MTHI
//   stall_o   out  1   combinational pipeline hold
//   we_o      out  1   one-cycle HI/LO write strobe
//   hi_o      out  32  HI write data
//   lo_o      out  32  LO write data
module risc32_muldiv_ctrl
   import risc32_muldiv_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 2
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic        annul_i,
   input  logic [31:0] hi_cur_i,
   input  logic [31:0] lo_cur_i,
   output logic        stall_o,
   output logic        we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_LAT - 1);

   md_state_e    state;
   logic         we_q;
   logic [32:0]  mul_a;
   logic [32:0]  mul_b;
   logic [63:0]  product;
   logic [MCW-1:0] mul_cnt;
   logic         q_neg;
   logic         r_neg;
   logic         accept;
   logic         div_signed;
   logic         div_load;
   logic [31:0]  div_dividend;
   logic [31:0]  div_divisor;
   logic         div_done;
   logic [31:0]  div_q;
   logic [31:0]  div_r;

   // Operands are held as 33-bit values (sign or zero extended by op) so one
   // 64-bit product serves both MULT and MULTU.
   assign product = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

   // A flush always wins over a stall so the pipeline can drain the annulled op.
   assign accept  = (state == ST_IDLE) && start_i && !annul_i;
   assign stall_o = !annul_i && (((state == ST_IDLE) && start_i && is_arith(op_i)) ||
                                 (state == ST_MUL) || (state == ST_DIV));

   // The strobe is registered, but a flush landing on the write cycle still
   // has to cancel the write, hence the final gate.
   assign we_o = we_q && !annul_i;

   // Divider is armed in cycle 0 with operand magnitudes; signs are fixed up
   // when the result is written back.
   assign div_signed   = (op_i == MD_OP_DIV);
   assign div_dividend = magnitude(rs_i, div_signed && rs_i[31]);
   assign div_divisor  = magnitude(rt_i, div_signed && rt_i[31]);
   assign div_load     = accept && ((op_i == MD_OP_DIV) || (op_i == MD_OP_DIVU)) &&
                         (rt_i != 32'd0);

   risc32_muldiv_ctrl_div_iter u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .step     (state == ST_DIV),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .done     (div_done),
      .q        (div_q),
      .r        (div_r)
   );

   // Controller FSM with registered write data. DONE is the write cycle; it
   // ignores start_i so an op held on start_i while stalled runs only once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         we_q    <= 1'b0;
         hi_o    <= '0;
         lo_o    <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         mul_cnt <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (op_i)
                     MD_OP_MULT: begin
                        mul_a   <= {rs_i[31], rs_i};
                        mul_b   <= {rt_i[31], rt_i};
                        mul_cnt <= '0;
                        state   <= ST_MUL;
                     end
                     MD_OP_MULTU: begin
                        mul_a   <= {1'b0, rs_i};
                        mul_b   <= {1'b0, rt_i};
                        mul_cnt <= '0;
                        state   <= ST_MUL;
                     end
                     MD_OP_DIV, MD_OP_DIVU: begin
                        if (rt_i == 32'd0) begin
                           we_q  <= 1'b1;
                           hi_o  <= rs_i;
                           lo_o  <= 32'hFFFF_FFFF;
                           state <= ST_DONE;
                        end else begin
                           q_neg <= div_signed && (rs_i[31] ^ rt_i[31]);
                           r_neg <= div_signed && rs_i[31];
                           state <= ST_DIV;
                        end
                     end
                     MD_OP_MTHI: begin
                        we_q  <= 1'b1;
                        hi_o  <= rs_i;
                        lo_o  <= lo_cur_i;
                        state <= ST_DONE;
                     end
                     MD_OP_MTLO: begin
                        we_q  <= 1'b1;
                        hi_o  <= hi_cur_i;
                        lo_o  <= rs_i;
                        state <= ST_DONE;
                     end
                     default: state <= ST_IDLE;
                  endcase
               end
            end
            ST_MUL: begin
               if (annul_i) begin
                  state <= ST_IDLE;
               end else if (mul_cnt == MUL_LAST) begin
                  we_q  <= 1'b1;
                  hi_o  <= product[63:32];
                  lo_o  <= product[31:0];
                  state <= ST_DONE;
               end else begin
                  mul_cnt <= mul_cnt + MCW'(1);
               end
            end
            ST_DIV: begin
               if (annul_i) begin
                  state <= ST_IDLE;
               end else if (div_done) begin
                  we_q  <= 1'b1;
                  hi_o  <= magnitude(div_r, r_neg);
                  lo_o  <= magnitude(div_q, q_neg);
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
